niosiisystem_tick_scheduler: RTL and testbench
==============================================

// Module: niosiisystem_tick_scheduler
// PURPOSE
//  Multiplexes NUM_CH software timeout channels onto one hardware tick: the timeout pulse of the
//  system interval timer. One shared decrementer is sequenced across the channels once per tick.
//  Expired channels are queued as pending and presented round-robin on one irq and ACTIVE register.
//  Avalon-MM 16-bit slave on the Nios II data bus, next to the interval timer.
// PARAMETERS
//  NUM_CH  4   number of channels, 1..16
//  CNT_W   16  channel count/reload width, fixed at 16 (one bus word)
// PORTS
//  clk        in   1      system clock; only clock
//  reset_n    in   1      asynchronous, active-low reset
//  tick       in   1      single-cycle tick pulse from the interval timer timeout
//  address    in   3      register word address
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe
//  writedata  in   16     write data
//  readdata   out  16     registered read data, 1-cycle latency
//  irq        out  1      ie && |pending (combinational from registers)
// BEHAVIOUR
//  Reset: readdata=0, irq=0, all registers 0, FSM=IDLE, rr_ptr=0, scan index=0.
//  Map (wr = chipselect & ~write_n):
//   0 STATUS   R: [0] any pending, [1] overrun, [2] scanning. Any write clears overrun.
//   1 CONTROL  RW: [0] ie, [1] run.
//   2 SELECT   RW: [3:0] channel index sel; index >= NUM_CH is ignored on writes, reads 0 on 3-5.
//   3 RELOAD   RW: reload[sel]. A write also sets count[sel] = writedata.
//   4 COUNT    R: count[sel].
//   5 CH_CTRL  RW: [0] enable[sel], [1] oneshot[sel].
//   6 PENDING  R: pending bitmap. Write-1-to-clear.
//   7 ACTIVE   R: [15] valid, [3:0] grant id. Any write = ack.
//  FSM IDLE/SCAN:
//   - IDLE: tick && run -> SCAN, idx=0. Tick with run=0 is ignored.
//   - SCAN: processes channel idx in that cycle. Last idx (NUM_CH-1) -> IDLE; otherwise idx+1.
//   - A full scan takes NUM_CH cycles. Clearing run mid-scan does not abort the scan.
//  Channel update (enable=1 only; disabled channels are untouched):
//   - count<=1: pending<=1, count<=reload. If oneshot, enable<=0.
//   - else: count<=count-1.
//   - Result: reload R fires every R ticks. R=0 behaves as R=1. No wrap below 0.
//  Overrun: tick in SCAN -> overrun<=1 and the tick is dropped (no queueing).
//  Round-robin: grant = first pending bit at or after rr_ptr, cyclic. valid = |pending.
//   - Ack with valid: clears pending[grant], rr_ptr <= (grant+1) mod NUM_CH.
//   - Ack without valid: no effect.
//  Same-cycle collisions:
//   - Scan set vs W1C/ack clear of the same bit: set wins (no lost events).
//   - Bus write to RELOAD/CH_CTRL vs scan update of the same channel: bus write wins for the written
//     fields. A scan-side pending set still happens.
//  Read data mux is sampled at the clock edge. readdata reflects register state before that edge's
//  updates.
//  Reset asserted mid-scan: immediate return to reset values, no partial state kept.
// STRUCTURE
//  Package niosiisystem_tick_sched_pkg holds:
//   - address constants ADDR_STATUS..ADDR_ACTIVE
//   - FSM state encoding ST_IDLE/ST_SCAN
//   - STATUS/CONTROL/CH_CTRL bit positions
//  Sub-module niosiisystem_tick_sched_rr_pick: combinational pick of {valid, grant} from
//  pending[NUM_CH] and rr_ptr. Top level holds the registers, FSM, shared decrementer and bus decode.
// TESTING
//  1. Reset, then read all 8 addresses -> all 0, irq=0.
//  2. ch0 reload=3, enable, run=1, ie=1; 6 ticks 100 cycles apart -> pending[0] set after tick 3
//     and tick 6. irq rises 1 cycle after tick 3 scan slot.
//  3. ch1 reload=2, oneshot=1; 4 ticks -> exactly one fire after tick 2, then enable[1]=0,
//     count[1]=2.
//  4. ch0..3 pending=4'b1111, rr_ptr=0; read ACTIVE then ack, 4 times -> ids 0,1,2,3, then valid=0.
//     With pending=4'b0101 and rr_ptr=1: grant=2.
//  5. Two ticks 2 cycles apart (NUM_CH=4) -> second tick dropped, STATUS[1]=1. Write STATUS -> 0.
//  6. W1C of pending[0] in the same cycle as ch0 fires -> pending[0] stays 1. RELOAD write during
//     ch0 scan slot -> count=written value.

Source files
------------

// File: rtl/niosiisystem_tick_sched_pkg.sv
// -----------------------------------------------------------------------------
// niosiisystem_tick_sched_pkg
// Shared definitions for the tick scheduler: Avalon register word addresses,
// the scan FSM state encoding and bit positions within the STATUS, CONTROL,
// CH_CTRL and ACTIVE registers.
// -----------------------------------------------------------------------------
package niosiisystem_tick_sched_pkg;

    // Register word addresses
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_SELECT  = 3'd2;
    localparam logic [2:0] ADDR_RELOAD  = 3'd3;
    localparam logic [2:0] ADDR_COUNT   = 3'd4;
    localparam logic [2:0] ADDR_CH_CTRL = 3'd5;
    localparam logic [2:0] ADDR_PENDING = 3'd6;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd7;

    // Scan sequencer states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } sched_state_e;

    // STATUS bits
    localparam int STATUS_PEND_BIT = 0;
    localparam int STATUS_OVR_BIT  = 1;
    localparam int STATUS_SCAN_BIT = 2;

    // CONTROL bits
    localparam int CTRL_IE_BIT  = 0;
    localparam int CTRL_RUN_BIT = 1;

    // CH_CTRL bits
    localparam int CHCTRL_EN_BIT = 0;
    localparam int CHCTRL_OS_BIT = 1;

    // ACTIVE bits
    localparam int ACTIVE_VALID_BIT = 15;

endpackage

// File: rtl/niosiisystem_tick_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// niosiisystem_tick_sched_rr_pick
// Combinational round-robin picker: selects the first set pending bit at or
// after rr_ptr, wrapping cyclically over NUM_CH channels.
// Ports:
//   pending  in  NUM_CH  pending bitmap
//   rr_ptr   in  4       round-robin start position (always < NUM_CH)
//   valid    out 1       any bit pending
//   grant    out 4       granted channel id (0 when nothing pending)
// -----------------------------------------------------------------------------
module niosiisystem_tick_sched_rr_pick #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [3:0]        rr_ptr,
    output logic              valid,
    output logic [3:0]        grant
);

    // Choose the pending channel with the smallest cyclic distance from rr_ptr
    always_comb begin
        int best_d;
        int d;
        best_d = NUM_CH;
        d      = 0;
        grant  = 4'd0;
        for (int j = 0; j < NUM_CH; j++) begin
            d = (j - int'(rr_ptr) + NUM_CH) % NUM_CH;
            if (pending[j] && (d < best_d)) begin
                best_d = d;
                grant  = 4'(j);
            end else begin
                best_d = best_d;
            end
        end
    end

    assign valid = |pending;

endmodule

// File: rtl/niosiisystem_tick_scheduler.sv
// -----------------------------------------------------------------------------
// niosiisystem_tick_scheduler
// Multiplexes NUM_CH software timeout channels onto the interval timer tick.
// On each accepted tick one shared decrementer walks the channels, one per
// cycle. Expiring channels become pending and are presented round-robin on
// ACTIVE and irq. 16-bit Avalon-MM slave, registered read data.
// Ports:
//   clk        in  1   system clock
//   reset_n    in  1   asynchronous active-low reset
//   tick       in  1   single-cycle tick from the interval timer
//   address    in  3   register word address
//   chipselect in  1   slave select
//   write_n    in  1   active-low write strobe
//   writedata  in  16  write data
//   readdata   out 16  read data, one cycle after the read
//   irq        out 1   ie && any pending
// -----------------------------------------------------------------------------
module niosiisystem_tick_scheduler
    import niosiisystem_tick_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CH - 1);
    localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

    sched_state_e      state_r, state_s;
    logic [3:0]        idx_r, idx_s;
    logic              ie_r, ie_s;
    logic              run_r, run_s;
    logic              overrun_r, overrun_s;
    logic [3:0]        sel_r, sel_s;
    logic [3:0]        rr_ptr_r, rr_ptr_s;
    logic [CNT_W-1:0]  reload_r [NUM_CH];
    logic [CNT_W-1:0]  reload_s [NUM_CH];
    logic [CNT_W-1:0]  count_r  [NUM_CH];
    logic [CNT_W-1:0]  count_s  [NUM_CH];
    logic [NUM_CH-1:0] enable_r, enable_s;
    logic [NUM_CH-1:0] oneshot_r, oneshot_s;
    logic [NUM_CH-1:0] pending_r, pending_s;
    logic [15:0]       readdata_r, rd_mux_s;
    logic              wr_s;
    logic              valid_s;
    logic [3:0]        grant_s;

    assign wr_s     = chipselect & ~write_n;
    assign readdata = readdata_r;
    assign irq      = ie_r & (|pending_r);

    niosiisystem_tick_sched_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .pending (pending_r),
        .rr_ptr  (rr_ptr_r),
        .valid   (valid_s),
        .grant   (grant_s)
    );

    // Next-state: bus writes, clears, scan sequencing and channel update
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        ie_s      = ie_r;
        run_s     = run_r;
        overrun_s = overrun_r;
        sel_s     = sel_r;
        rr_ptr_s  = rr_ptr_r;
        reload_s  = reload_r;
        count_s   = count_r;
        enable_s  = enable_r;
        oneshot_s = oneshot_r;
        pending_s = pending_r;

        if (wr_s && (address == ADDR_CONTROL)) begin
            ie_s  = writedata[CTRL_IE_BIT];
            run_s = writedata[CTRL_RUN_BIT];
        end else begin
            ie_s  = ie_r;
        end

        if (wr_s && (address == ADDR_STATUS)) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end

        if (wr_s && (address == ADDR_SELECT) && ({1'b0, writedata[3:0]} < NUM_CH_W)) begin
            sel_s = writedata[3:0];
        end else begin
            sel_s = sel_r;
        end

        // Clears are applied before scan sets so a same-cycle expiry is never lost
        if (wr_s && (address == ADDR_PENDING)) begin
            pending_s = pending_r & ~writedata[NUM_CH-1:0];
        end else begin
            pending_s = pending_r;
        end

        if (wr_s && (address == ADDR_ACTIVE) && valid_s) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (grant_s == 4'(j)) begin
                    pending_s[j] = 1'b0;
                end else begin
                    pending_s[j] = pending_s[j];
                end
            end
            rr_ptr_s = (grant_s == LAST_IDX) ? 4'd0 : (grant_s + 4'd1);
        end else begin
            rr_ptr_s = rr_ptr_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (tick && run_r) begin
                    state_s = ST_SCAN;
                    idx_s   = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                // A tick arriving mid-scan is dropped and flagged
                if (tick) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_s;
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if ((idx_r == 4'(i)) && enable_r[i]) begin
                        // count<=1 covers reload 0 behaving as reload 1
                        if (count_r[i] <= CNT_W'(1)) begin
                            pending_s[i] = 1'b1;
                            count_s[i]   = reload_r[i];
                            if (oneshot_r[i]) begin
                                enable_s[i] = 1'b0;
                            end else begin
                                enable_s[i] = enable_r[i];
                            end
                        end else begin
                            count_s[i] = count_r[i] - CNT_W'(1);
                        end
                    end else begin
                        count_s[i] = count_s[i];
                    end
                end
                if (idx_r == LAST_IDX) begin
                    state_s = ST_IDLE;
                    idx_s   = 4'd0;
                end else begin
                    idx_s   = idx_r + 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = 4'd0;
            end
        endcase

        // Bus writes to channel fields override the scan result for those fields
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_s && (address == ADDR_RELOAD) && (sel_r == 4'(i))) begin
                reload_s[i] = writedata[CNT_W-1:0];
                count_s[i]  = writedata[CNT_W-1:0];
            end else begin
                reload_s[i] = reload_s[i];
            end
            if (wr_s && (address == ADDR_CH_CTRL) && (sel_r == 4'(i))) begin
                enable_s[i]  = writedata[CHCTRL_EN_BIT];
                oneshot_s[i] = writedata[CHCTRL_OS_BIT];
            end else begin
                oneshot_s[i] = oneshot_s[i];
            end
        end
    end

    // Read data mux from current register state
    always_comb begin
        rd_mux_s = 16'h0000;
        case (address)
            ADDR_STATUS: begin
                rd_mux_s[STATUS_PEND_BIT] = |pending_r;
                rd_mux_s[STATUS_OVR_BIT]  = overrun_r;
                rd_mux_s[STATUS_SCAN_BIT] = (state_r == ST_SCAN);
            end
            ADDR_CONTROL: begin
                rd_mux_s[CTRL_IE_BIT]  = ie_r;
                rd_mux_s[CTRL_RUN_BIT] = run_r;
            end
            ADDR_SELECT: begin
                rd_mux_s[3:0] = sel_r;
            end
            ADDR_RELOAD, ADDR_COUNT, ADDR_CH_CTRL: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (sel_r == 4'(i)) begin
                        if (address == ADDR_RELOAD) begin
                            rd_mux_s = reload_r[i];
                        end else if (address == ADDR_COUNT) begin
                            rd_mux_s = count_r[i];
                        end else begin
                            rd_mux_s[CHCTRL_EN_BIT] = enable_r[i];
                            rd_mux_s[CHCTRL_OS_BIT] = oneshot_r[i];
                        end
                    end else begin
                        rd_mux_s = rd_mux_s;
                    end
                end
            end
            ADDR_PENDING: begin
                rd_mux_s[NUM_CH-1:0] = pending_r;
            end
            ADDR_ACTIVE: begin
                rd_mux_s[ACTIVE_VALID_BIT] = valid_s;
                rd_mux_s[3:0]              = grant_s;
            end
            default: begin
                rd_mux_s = 16'h0000;
            end
        endcase
    end

    // State and register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= 4'd0;
            ie_r      <= 1'b0;
            run_r     <= 1'b0;
            overrun_r <= 1'b0;
            sel_r     <= 4'd0;
            rr_ptr_r  <= 4'd0;
            enable_r  <= {NUM_CH{1'b0}};
            oneshot_r <= {NUM_CH{1'b0}};
            pending_r <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                reload_r[i] <= {CNT_W{1'b0}};
                count_r[i]  <= {CNT_W{1'b0}};
            end
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            ie_r      <= ie_s;
            run_r     <= run_s;
            overrun_r <= overrun_s;
            sel_r     <= sel_s;
            rr_ptr_r  <= rr_ptr_s;
            enable_r  <= enable_s;
            oneshot_r <= oneshot_s;
            pending_r <= pending_s;
            for (int i = 0; i < NUM_CH; i++) begin
                reload_r[i] <= reload_s[i];
                count_r[i]  <= count_s[i];
            end
        end
    end

    // Registered read data; zero when no read is in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 16'h0000;
        end else if (chipselect && write_n) begin
            readdata_r <= rd_mux_s;
        end else begin
            readdata_r <= 16'h0000;
        end
    end

endmodule

// File: tb/tb_niosiisystem_tick_scheduler.sv
module tb_niosiisystem_tick_scheduler;
    import niosiisystem_tick_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    niosiisystem_tick_scheduler #(.NUM_CH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        reset_n = 1'b0; tick = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = 16'h0000;
        idle(3);
        reset_n = 1'b1;
        idle(2);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            tests_run++;
            if (rd !== 16'h0000) begin
                tests_failed++;
                $display("FAIL reset_read addr%0d: got %h expected 0000", a, rd);
            end
        end
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_periodic();
        logic [15:0] rd;
        logic        fire;
        bus_write(ADDR_SELECT, 16'd0);
        bus_write(ADDR_RELOAD, 16'd3);
        bus_write(ADDR_CH_CTRL, 16'h0001);
        bus_write(ADDR_CONTROL, 16'h0003);
        for (int t = 1; t <= 6; t++) begin
            fire = ((t % 3) == 0);
            pulse_tick();
            tests_run++;
            if (irq !== 1'b0) begin
                tests_failed++;
                $display("FAIL periodic_irq_pre t%0d: got %b expected 0", t, irq);
            end
            @(negedge clk);
            tests_run++;
            if (irq !== fire) begin
                tests_failed++;
                $display("FAIL periodic_irq_slot t%0d: got %b expected %b", t, irq, fire);
            end
            idle(100);
            bus_read(ADDR_PENDING, rd);
            tests_run++;
            if (rd !== (fire ? 16'h0001 : 16'h0000)) begin
                tests_failed++;
                $display("FAIL periodic_pending t%0d: got %h expected %h", t, rd,
                         fire ? 16'h0001 : 16'h0000);
            end
            if (fire) bus_write(ADDR_PENDING, 16'h0001);
        end
        bus_write(ADDR_CH_CTRL, 16'h0000);
    endtask

    task automatic test_oneshot();
        logic [15:0] rd;
        logic [15:0] exp;
        bus_write(ADDR_SELECT, 16'd1);
        bus_write(ADDR_RELOAD, 16'd2);
        bus_write(ADDR_CH_CTRL, 16'h0003);
        for (int t = 1; t <= 4; t++) begin
            pulse_tick();
            idle(10);
            exp = (t == 2) ? 16'h0002 : 16'h0000;
            bus_read(ADDR_PENDING, rd);
            tests_run++;
            if (rd !== exp) begin
                tests_failed++;
                $display("FAIL oneshot_pending t%0d: got %h expected %h", t, rd, exp);
            end
            if (t == 2) bus_write(ADDR_PENDING, 16'h0002);
        end
        bus_read(ADDR_CH_CTRL, rd);
        tests_run++;
        if (rd !== 16'h0002) begin
            tests_failed++;
            $display("FAIL oneshot_chctrl: got %h expected 0002", rd);
        end
        bus_read(ADDR_COUNT, rd);
        tests_run++;
        if (rd !== 16'd2) begin
            tests_failed++;
            $display("FAIL oneshot_count: got %h expected 0002", rd);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] rd;
        for (int i = 0; i < 4; i++) begin
            bus_write(ADDR_SELECT, 16'(i));
            bus_write(ADDR_RELOAD, 16'd1);
            bus_write(ADDR_CH_CTRL, 16'h0003);
        end
        pulse_tick();
        idle(10);
        bus_read(ADDR_PENDING, rd);
        tests_run++;
        if (rd !== 16'h000F) begin
            tests_failed++;
            $display("FAIL rr_pending_all: got %h expected 000f", rd);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(ADDR_ACTIVE, rd);
            tests_run++;
            if (rd !== (16'h8000 | 16'(i))) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got %h expected %h", i, rd, 16'h8000 | 16'(i));
            end
            bus_write(ADDR_ACTIVE, 16'h0000);
        end
        bus_read(ADDR_ACTIVE, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rr_empty: got %h expected 0000", rd);
        end
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_irq_empty: got %b expected 0", irq);
        end
        // Move rr_ptr to 1 by acking ch0, then present pending=0101
        bus_write(ADDR_SELECT, 16'd0);
        bus_write(ADDR_CH_CTRL, 16'h0003);
        bus_write(ADDR_SELECT, 16'd2);
        bus_write(ADDR_CH_CTRL, 16'h0003);
        pulse_tick();
        idle(10);
        bus_read(ADDR_ACTIVE, rd);
        tests_run++;
        if (rd !== 16'h8000) begin
            tests_failed++;
            $display("FAIL rr_setup_grant0: got %h expected 8000", rd);
        end
        bus_write(ADDR_ACTIVE, 16'h0000);
        bus_write(ADDR_SELECT, 16'd0);
        bus_write(ADDR_CH_CTRL, 16'h0003);
        pulse_tick();
        idle(10);
        bus_read(ADDR_PENDING, rd);
        tests_run++;
        if (rd !== 16'h0005) begin
            tests_failed++;
            $display("FAIL rr_pending_0101: got %h expected 0005", rd);
        end
        bus_read(ADDR_ACTIVE, rd);
        tests_run++;
        if (rd !== 16'h8002) begin
            tests_failed++;
            $display("FAIL rr_ptr1_grant: got %h expected 8002", rd);
        end
        bus_write(ADDR_ACTIVE, 16'h0000);
        bus_read(ADDR_ACTIVE, rd);
        tests_run++;
        if (rd !== 16'h8000) begin
            tests_failed++;
            $display("FAIL rr_wrap_grant: got %h expected 8000", rd);
        end
        bus_write(ADDR_ACTIVE, 16'h0000);
        bus_write(ADDR_ACTIVE, 16'h0000);
        bus_read(ADDR_PENDING, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rr_pending_drained: got %h expected 0000", rd);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] rd;
        bus_write(ADDR_SELECT, 16'd0);
        bus_write(ADDR_RELOAD, 16'd10);
        bus_write(ADDR_CH_CTRL, 16'h0001);
        pulse_tick();
        bus_read(ADDR_STATUS, rd);
        tests_run++;
        if (rd !== 16'h0004) begin
            tests_failed++;
            $display("FAIL status_scanning: got %h expected 0004", rd);
        end
        idle(10);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        idle(10);
        bus_read(ADDR_STATUS, rd);
        tests_run++;
        if (rd !== 16'h0002) begin
            tests_failed++;
            $display("FAIL overrun_flag: got %h expected 0002", rd);
        end
        bus_read(ADDR_COUNT, rd);
        tests_run++;
        if (rd !== 16'd8) begin
            tests_failed++;
            $display("FAIL overrun_dropped: got %h expected 0008", rd);
        end
        bus_write(ADDR_STATUS, 16'h0000);
        bus_read(ADDR_STATUS, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL overrun_clear: got %h expected 0000", rd);
        end
        bus_write(ADDR_CH_CTRL, 16'h0000);
    endtask

    task automatic test_collisions();
        logic [15:0] rd;
        bus_write(ADDR_SELECT, 16'd0);
        bus_write(ADDR_RELOAD, 16'd1);
        bus_write(ADDR_CH_CTRL, 16'h0001);
        pulse_tick();
        idle(10);
        // W1C lands on the same edge as ch0 fires
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        chipselect = 1'b1; write_n = 1'b0; address = ADDR_PENDING; writedata = 16'h0001;
        @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
        idle(10);
        bus_read(ADDR_PENDING, rd);
        tests_run++;
        if (rd !== 16'h0001) begin
            tests_failed++;
            $display("FAIL w1c_vs_fire: got %h expected 0001", rd);
        end
        bus_write(ADDR_PENDING, 16'h0001);
        bus_read(ADDR_PENDING, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL w1c_plain: got %h expected 0000", rd);
        end
        // RELOAD write lands on ch0's scan slot
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        chipselect = 1'b1; write_n = 1'b0; address = ADDR_RELOAD; writedata = 16'd7;
        @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
        idle(10);
        bus_read(ADDR_COUNT, rd);
        tests_run++;
        if (rd !== 16'd7) begin
            tests_failed++;
            $display("FAIL reload_vs_scan_count: got %h expected 0007", rd);
        end
        bus_read(ADDR_RELOAD, rd);
        tests_run++;
        if (rd !== 16'd7) begin
            tests_failed++;
            $display("FAIL reload_vs_scan_reload: got %h expected 0007", rd);
        end
        bus_read(ADDR_PENDING, rd);
        tests_run++;
        if (rd !== 16'h0001) begin
            tests_failed++;
            $display("FAIL reload_vs_scan_pending: got %h expected 0001", rd);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [15:0] rd;
        pulse_tick();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_irq: got %b expected 0", irq);
        end
        bus_read(ADDR_STATUS, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midreset_status: got %h expected 0000", rd);
        end
        bus_read(ADDR_CONTROL, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midreset_control: got %h expected 0000", rd);
        end
        bus_read(ADDR_COUNT, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midreset_count: got %h expected 0000", rd);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_round_robin();
        test_overrun();
        test_collisions();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
